// File: rtl/divider_if.sv
// Handshake and result bundle between the execute stage and the multi-cycle divider.
interface divider_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        div_stall;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  result_o, ready_o, div_stall
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output result_o, ready_o, div_stall
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring DIV/DIVU for the MIPS32 execute stage; result = {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes in one cycle.
module divider (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      stateNext_s;
  logic [4:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] divisor_r;
  logic [31:0] rem_r;
  logic        qNeg_r;
  logic        rNeg_r;
  logic [63:0] result_r;

  logic        accept_s;
  logic        zeroFast_s;
  logic [32:0] shifted_s;
  logic        bitOk_s;
  logic [31:0] remNext_s;
  logic [31:0] quoNext_s;
  logic        divStall_s;

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] negIf(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

  assign accept_s = (state_r == IDLE) && bus.start_i && !bus.annul_i;

`ifdef DIV_ZERO_FAST_EN
  assign zeroFast_s = accept_s && (bus.b_i == 32'd0);
`else
  assign zeroFast_s = 1'b0;
`endif

  // One restoring step: the 33-bit partial remainder never exceeds 2*|b|-1,
  // so a successful subtraction always fits back into 32 bits.
  always_comb begin
    shifted_s = {rem_r, quo_r[31]};
    bitOk_s   = (shifted_s >= {1'b0, divisor_r});
    if (bitOk_s) begin
      remNext_s = shifted_s[31:0] - divisor_r;
    end else begin
      remNext_s = shifted_s[31:0];
    end
    quoNext_s = {quo_r[30:0], bitOk_s};
  end

  // Next-state logic; annul from any state returns to IDLE.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && zeroFast_s) begin
          stateNext_s = DONE;
        end else if (accept_s) begin
          stateNext_s = RUN;
        end else begin
          stateNext_s = IDLE;
        end
      end
      RUN: begin
        if (bus.annul_i) begin
          stateNext_s = IDLE;
        end else if (cnt_r == 5'd31) begin
          stateNext_s = DONE;
        end else begin
          stateNext_s = RUN;
        end
      end
      DONE:    stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Stall covers the issue cycle so the hazard unit freezes E before RUN begins.
  always_comb begin
    divStall_s = accept_s || (state_r == RUN);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Operand capture, iteration and signed result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 5'd0;
      quo_r     <= 32'd0;
      divisor_r <= 32'd0;
      rem_r     <= 32'd0;
      qNeg_r    <= 1'b0;
      rNeg_r    <= 1'b0;
      result_r  <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            quo_r     <= absVal(bus.a_i, bus.signed_i);
            divisor_r <= absVal(bus.b_i, bus.signed_i);
            qNeg_r    <= (bus.a_i[31] ^ bus.b_i[31]) & bus.signed_i;
            rNeg_r    <= bus.a_i[31] & bus.signed_i;
            rem_r     <= 32'd0;
            cnt_r     <= 5'd0;
            if (zeroFast_s) begin
              result_r <= {bus.a_i,
                           (bus.signed_i && bus.a_i[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
            end
          end
        end
        RUN: begin
          if (!bus.annul_i) begin
            rem_r <= remNext_s;
            quo_r <= quoNext_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              result_r <= {negIf(remNext_s, rNeg_r), negIf(quoNext_s, qNeg_r)};
            end
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.result_o  = result_r;
  assign bus.ready_o   = (state_r == DONE);
  assign bus.div_stall = divStall_s;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected {hi, lo} and latency queued at issue, checked on ready_o.
module tb_divider;

  logic clk = 1'b0;
  logic rst;

  divider_if ifc ();

  divider dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          startCyc;
  } expEntry_t;

  expEntry_t   expQ[$];
  expEntry_t   monE;
  int          cycleCount = 0;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] lastRes = 64'd0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      r = a;
      q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Result/latency checker driven by the DUT's ready pulse.
  always @(negedge clk) begin
    if (!rst && ifc.ready_o) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_ready", 64'd1, 64'd0);
      end else begin
        monE = expQ.pop_front();
        checkVal("result", ifc.result_o, monE.res);
        checkVal("latency", 64'(cycleCount - monE.startCyc), 64'(monE.lat));
      end
    end
  end

  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    expEntry_t e;
    int  lat;
    int  stallCnt;
    bit  seen;
    lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) lat = 1;
`endif
    @(negedge clk);
    ifc.start_i  = 1'b1;
    ifc.signed_i = sgn;
    ifc.a_i      = a;
    ifc.b_i      = b;
    e.res      = refDiv(sgn, a, b);
    e.lat      = lat;
    e.startCyc = cycleCount;
    expQ.push_back(e);
    lastRes = e.res;
    #1;
    checkVal("stall_issue", 64'(ifc.div_stall), 64'd1);
    stallCnt = ifc.div_stall ? 1 : 0;
    @(posedge clk);
    #1;
    ifc.start_i = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (ifc.ready_o) begin
        seen = 1'b1;
        checkVal("stall_done", 64'(ifc.div_stall), 64'd0);
      end else if (ifc.div_stall) begin
        stallCnt++;
      end
    end
    checkVal("ready_seen", 64'(seen), 64'd1);
    checkVal("stall_cycles", 64'(stallCnt), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    ifc.start_i  = 1'b0;
    ifc.signed_i = 1'b0;
    ifc.a_i      = 32'd0;
    ifc.b_i      = 32'd0;
    ifc.annul_i  = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rst_result", ifc.result_o, 64'd0);
    checkVal("rst_ready", 64'(ifc.ready_o), 64'd0);
    checkVal("rst_stall", 64'(ifc.div_stall), 64'd0);
    rst = 1'b0;

    runDiv(1'b0, 32'd100, 32'd7);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2);
    runDiv(1'b1, 32'd7, 32'hFFFF_FFFE);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runDiv(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    runDiv(1'b0, 32'h1234_5678, 32'd0);
    runDiv(1'b1, 32'h8000_0005, 32'd0);

    // start together with annul in IDLE must not launch anything
    @(negedge clk);
    ifc.start_i = 1'b1;
    ifc.annul_i = 1'b1;
    ifc.a_i     = 32'd9;
    ifc.b_i     = 32'd3;
    #1;
    checkVal("idle_annul_stall", 64'(ifc.div_stall), 64'd0);
    @(posedge clk);
    #1;
    ifc.start_i = 1'b0;
    ifc.annul_i = 1'b0;
    @(negedge clk);
    checkVal("idle_annul_ready", 64'(ifc.ready_o), 64'd0);

    // annul at cycle 10 of a running divide
    @(negedge clk);
    ifc.start_i  = 1'b1;
    ifc.signed_i = 1'b0;
    ifc.a_i      = 32'd100;
    ifc.b_i      = 32'd7;
    @(posedge clk);
    #1;
    ifc.start_i = 1'b0;
    repeat (10) @(negedge clk);
    checkVal("annul_stall_pre", 64'(ifc.div_stall), 64'd1);
    ifc.annul_i = 1'b1;
    @(posedge clk);
    #1;
    ifc.annul_i = 1'b0;
    @(negedge clk);
    checkVal("annul_stall_post", 64'(ifc.div_stall), 64'd0);
    checkVal("annul_ready", 64'(ifc.ready_o), 64'd0);
    checkVal("annul_result_held", ifc.result_o, lastRes);
    runDiv(1'b0, 32'd50, 32'd5);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    ifc.start_i  = 1'b1;
    ifc.signed_i = 1'b1;
    ifc.a_i      = 32'hFFFF_0000;
    ifc.b_i      = 32'd3;
    @(posedge clk);
    #1;
    ifc.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkVal("midrst_stall", 64'(ifc.div_stall), 64'd0);
    checkVal("midrst_ready", 64'(ifc.ready_o), 64'd0);
    checkVal("midrst_result", ifc.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    runDiv(1'b0, 32'd1000, 32'd3);

    for (int i = 0; i < 4; i++) begin
      runDiv(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom_range(1, 65535)));
    end

    @(negedge clk);
    checkVal("queue_empty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Multi-cycle 32-bit integer divider for the execute stage of the MIPS32 pipeline. It implements DIV and DIVU with a radix-2 restoring algorithm at one quotient bit per cycle. It asserts `div_stall` to the hazard unit, which holds F/D/E while a division is in flight. The 64-bit result feeds the HI/LO write path as {remainder, quotient}.

## Interface
- No parameters; operand width is fixed at 32.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_i` input 1: DIV/DIVU is present in E.
- `signed_i` input 1: 1 = DIV (two's complement), 0 = DIVU; sampled with operands.
- `a_i` input 32: dividend (forwarded rs value in E).
- `b_i` input 32: divisor (forwarded rt value in E).
- `annul_i` input 1: abort the current division (exception flush of E).
- `result_o` output 64: {hi = remainder, lo = quotient}.
- `ready_o` output 1: `result_o` is valid this cycle.
- `div_stall` output 1: to the hazard unit; freeze F/D/E.

## Operation
- States:
  - IDLE: waiting for `start_i`.
  - RUN: iterating; 5-bit counter `cnt` runs 0..31.
  - DONE: one-cycle result presentation.
- Transitions:
  - IDLE & `start_i` & !`annul_i`: go to RUN. On the same edge, latch |a|, |b| (absolute values when `signed_i`, raw otherwise), the quotient sign (a[31]^b[31])&signed, the remainder sign a[31]&signed, and clear the partial remainder and `cnt`.
  - RUN: each cycle, shift the next dividend bit (MSB first) into the 33-bit partial remainder and subtract |b|. If the difference is non-negative, the quotient bit is 1 and the remainder takes the difference; otherwise the quotient bit is 0 and the remainder is kept.
  - RUN with `cnt`==31: go to DONE. On that edge, register `result_o` with signs applied. The quotient is negated if the quotient sign is set; the remainder is negated if the remainder sign is set.
  - DONE: go to IDLE unconditionally. Any `start_i` seen in the following IDLE cycle belongs to the next instruction.
  - `annul_i` in any state: go to IDLE next edge. No `ready_o` pulse; `result_o` is unchanged.
- Outputs:
  - `div_stall` = (IDLE & `start_i` & !`annul_i`) | RUN. It is combinational and low in DONE, so the pipeline advances on the DONE edge.
  - `ready_o` = (state==DONE).
  - `result_o` holds its value until the next DONE.
- Arithmetic:
  - 0x80000000 / -1 (signed) wraps: lo=0x80000000, hi=0.
  - Remainder sign always follows the dividend.
- Reset: state IDLE, `cnt` 0, `result_o` 0, `ready_o` 0, `div_stall` 0. Reset mid-RUN discards the operation immediately.

## Timing
- Cycle 0: IDLE with `start_i`; `div_stall`=1.
- Cycles 1..32: RUN; `div_stall`=1.
- Cycle 33: DONE; `ready_o`=1, `div_stall`=0, result valid.
- Total stall: 33 cycles. Issue-to-result latency: 33 cycles.
- Back-to-back divides: the earliest next `start_i` is cycle 34 (IDLE).
- `annul_i` at cycle k: `div_stall` goes low combinationally in IDLE, and at edge k+1 from RUN.

## Configuration
- `DIV_ZERO_FAST_EN`
  - Defined: in IDLE, `start_i` with `b_i`==0 goes directly to DONE. Stall is 1 cycle; `ready_o` appears at cycle 1. Result: hi = a_i; lo = 32'h00000001 if signed & a_i[31], else 32'hFFFFFFFF.
  - Undefined: divide-by-zero runs the full 33-cycle sequence. The restoring algorithm produces the same values as the defined case.

## Test plan
- Unsigned 100/7 (`signed_i`=0) -> `ready_o` at cycle 33, `result_o`={32'd2, 32'd14}; `div_stall` high for cycles 0..32 exactly.
- Signed -7/2 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFD. Signed 7/-2 -> hi=1, lo=32'hFFFFFFFD.
- Signed 0x80000000 / 0xFFFFFFFF -> hi=0, lo=0x80000000. Unsigned same operands -> hi=0x80000000, lo=0.
- 0x12345678 / 0: with `DIV_ZERO_FAST_EN`, ready at cycle 1. Without it, ready at cycle 33. Both give hi=0x12345678, lo=0xFFFFFFFF.
- `annul_i` pulsed at cycle 10 of RUN -> IDLE at cycle 11, no `ready_o`, `result_o` unchanged. A new start at cycle 12 (50/5) -> lo=10, hi=0 at cycle 45.
- `rst` asserted mid-RUN (asynchronous, between edges) -> `div_stall`, `ready_o`, `result_o` go to 0 immediately; after release, a fresh divide completes normally.
